// File: rtl/vga_timing_if.sv
// vga_timing_if: timing outputs of vga_timing_gen toward the VGA port and pixel generator.
//   hsync, vsync  : active-low syncs (registered)
//   video_on      : visible-area qualifier
//   p_tick        : one-clock pixel-enable strobe
//   frame_tick    : one-clock strobe when (x, y) wraps to (0, 0)
//   x, y          : pixel / line counters
interface vga_timing_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
    logic [9:0] x;
    logic [9:0] y;

    modport master (
        output hsync, vsync, video_on, p_tick, frame_tick, x, y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, frame_tick, x, y
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA timing from a 100 MHz clock.
//   clk_100MHz : system clock, rising edge
//   reset      : synchronous active-low reset
//   vga        : timing outputs (master side of vga_timing_if)
module vga_timing_gen #(
    parameter int unsigned HD       = 640,
    parameter int unsigned HF       = 16,
    parameter int unsigned HR       = 96,
    parameter int unsigned HB       = 48,
    parameter int unsigned VD       = 480,
    parameter int unsigned VF       = 10,
    parameter int unsigned VR       = 2,
    parameter int unsigned VB       = 33,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic         clk_100MHz,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int unsigned HMAX  = HD + HF + HR + HB;
    localparam int unsigned VMAX  = VD + VF + VR + VB;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             p_tick_q, p_tick_d;
    logic             frame_tick_q, frame_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             div_last, h_last, v_last;

    // Next-state: divider, counters, and syncs decoded from next-state counters
    always_comb begin
        div_last     = (div_q == DIV_W'(TICK_DIV - 1));
        h_last       = (h_q == CNT_W'(HMAX - 1));
        v_last       = (v_q == CNT_W'(VMAX - 1));

        div_d        = div_last ? '0 : div_q + DIV_W'(1);
        // Registered on the terminal divider count, so the first strobe
        // lands TICK_DIV clocks after reset release.
        p_tick_d     = div_last;
        h_d          = h_q;
        v_d          = v_q;
        frame_tick_d = 1'b0;

        if (p_tick_q) begin
            h_d = h_last ? '0 : h_q + CNT_W'(1);
            if (h_last) begin
                v_d          = v_last ? '0 : v_q + CNT_W'(1);
                frame_tick_d = v_last;
            end
        end

        hsync_d = !((h_d >= CNT_W'(HD + HF)) && (h_d <= CNT_W'(HD + HF + HR - 1)));
        vsync_d = !((v_d >= CNT_W'(VD + VF)) && (v_d <= CNT_W'(VD + VF + VR - 1)));
    end

    // State registers
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            p_tick_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            p_tick_q     <= p_tick_d;
            frame_tick_q <= frame_tick_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

    assign vga.x          = h_q;
    assign vga.y          = v_q;
    assign vga.p_tick     = p_tick_q;
    assign vga.frame_tick = frame_tick_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = (h_q < CNT_W'(HD)) && (v_q < CNT_W'(VD));

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock.
- Outputs a 25 MHz pixel-enable strobe, horizontal and vertical pixel counters (x, y), and active-low hsync/vsync to the VGA port.
- Outputs a video_on qualifier, plus a frame-start strobe for game-state update logic.
- Drives the x/y/video_on inputs of the pixel colour generator; that generator's rgb output goes to the VGA port alongside this block's syncs.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch (pixels)
- HR, 96, horizontal retrace/sync width (pixels)
- HB, 48, horizontal back porch (pixels)
- VD, 480, vertical display lines
- VF, 10, vertical front porch (lines)
- VR, 2, vertical retrace/sync width (lines)
- VB, 33, vertical back porch (lines)
- TICK_DIV, 4, system clocks per pixel (must be >= 2)

Ports:
- clk_100MHz  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- hsync  output  1  horizontal sync, active low, registered
- vsync  output  1  vertical sync, active low, registered
- video_on  output  1  high while (x < HD) and (y < VD)
- p_tick  output  1  one-clock pixel-enable pulse, every TICK_DIV clocks
- frame_tick  output  1  one-clock pulse when counters wrap to (0,0)
- x  output  10  horizontal pixel count, 0 .. HMAX-1
- y  output  10  vertical line count, 0 .. VMAX-1

Behaviour:
- HMAX = HD+HF+HR+HB = 800 and VMAX = VD+VF+VR+VB = 525, derived locally.
- Tick divider:
  - Counter cycles 0..TICK_DIV-1, incrementing every clock.
  - p_tick is registered and is high for exactly the clock in which the divider equals TICK_DIV-1. Period is 4 clocks at default.
- Horizontal counter h:
  - Advances only in a clock where p_tick is high.
  - At HMAX-1 it wraps to 0 and enables the vertical step. Otherwise it increments by 1.
- Vertical counter v:
  - Advances only when p_tick is high and h == HMAX-1.
  - Wraps VMAX-1 -> 0. Otherwise it increments by 1.
- x = h register and y = v register; no extra latency.
- Counters never exceed HMAX-1 / VMAX-1. Widths are 10 bits, with no overflow at the defaults.
- hsync:
  - Registered. Computed from the next-state h so it changes in the same clock as x.
  - Low when HD+HF <= h <= HD+HF+HR-1 (656..751), otherwise high.
- vsync:
  - Registered. Computed from the next-state v.
  - Low when VD+VF <= v <= VD+VF+VR-1 (490..491), otherwise high.
- video_on is combinational from the registered h/v. It is valid in the same cycle as x, y.
- frame_tick is registered. It is high for one clock in the clock where h and v both take value 0 via wrap, i.e. the clock after the p_tick that wrapped them.
- Reset (reset == 0 at a rising edge), all values apply the following cycle:
  - divider 0, h 0, v 0
  - p_tick 0, frame_tick 0
  - hsync 1, vsync 1
  - x 0, y 0, so video_on is 1
- Reset mid-frame or mid-sync: all state returns to reset values on that edge; no partial sync pulse is extended.
- On reset release, the first p_tick occurs TICK_DIV clocks later.

Test Plan:
- Reset held low 5 clocks, then released -> during reset x=0, y=0, hsync=1, vsync=1, p_tick=0, video_on=1; first p_tick exactly 4 clocks after release.
- Free-run one line -> p_tick every 4 clocks; x steps 0..799 then 0 with y+1; line period 3200 clocks.
- Free-run one line, checking hsync -> hsync low exactly while x in 656..751; 96 pixels = 384 clocks low; edges coincide with x change.
- Free-run full frame -> vsync low exactly for y=490 and 491 (1600 p_ticks); frame_tick period 420000 p_ticks = 1,680,000 clocks; frame_tick occurs once with x=0, y=0.
- Scan checks on video_on -> high for x<640 and y<480; low at x=640, y=0 and at x=0, y=480; total high pixels per frame = 307200.
- Assert reset for 1 clock while x=700, y=491 (both syncs low) -> next clock hsync=1, vsync=1, x=0, y=0; timing restarts as after power-up.
